// File: rtl/ped_xing_pkg.sv
// Shared state encoding and lamp patterns for the pedestrian-crossing controller.
// Lamp vectors are ordered {tr, ty, tg, pr, pg}.
package ped_xing_pkg;

  typedef enum logic [2:0] {
    GREEN  = 3'd0,
    YELLOW = 3'd1,
    ALLRED = 3'd2,
    WALK   = 3'd3,
    FLASH  = 3'd4,
    CLEAR  = 3'd5,
    MINGRN = 3'd6
  } xing_state_t;

  localparam logic [4:0] LAMP_GREEN  = 5'b00110;
  localparam logic [4:0] LAMP_YELLOW = 5'b01010;
  localparam logic [4:0] LAMP_ALLRED = 5'b10010;
  localparam logic [4:0] LAMP_WALK   = 5'b10001;
  localparam logic [3:0] LAMP_FLASH  = 4'b1000;  // pg supplied by flash_ph
  localparam logic [4:0] LAMP_CLEAR  = 5'b10010;
  localparam logic [4:0] LAMP_MINGRN = 5'b00110;

endpackage

// File: rtl/ped_xing_ctrl_param_timer.sv
// Phase timer: counts tick strobes within a phase, flags the last tick of a term-long phase.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign done = en && (count_q == term - CNT_W'(1));

endmodule

// File: rtl/ped_xing_ctrl_param.sv
// Pedestrian-crossing controller: 7-phase lamp sequencer with request recall and
// a minimum traffic-green phase that cannot be cut short by a button press.
module ped_xing_ctrl_param
  import ped_xing_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int T_YEL       = 2,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 6,
  parameter int T_FLASH     = 6,
  parameter int T_CLEAR     = 2,
  parameter int T_MIN_GREEN = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       nb,
  input  logic       sb,
  output logic       tr,
  output logic       ty,
  output logic       tg,
  output logic       pr,
  output logic       pg,
  output logic       wait_lamp,
  output logic [2:0] phase
);

  localparam int T_MAX = (1 << CNT_W) - 1;

  if (T_YEL < 1 || T_YEL > T_MAX || T_ALLRED < 1 || T_ALLRED > T_MAX ||
      T_WALK < 1 || T_WALK > T_MAX || T_FLASH < 1 || T_FLASH > T_MAX ||
      T_CLEAR < 1 || T_CLEAR > T_MAX || T_MIN_GREEN < 1 || T_MIN_GREEN > T_MAX) begin : g_bad_timing
    $error("ped_xing_ctrl_param: every T_* must lie in 1..2**CNT_W-1");
  end

  xing_state_t      state_q, state_d;
  logic             req_pend_q, req_pend_d;
  logic             flash_ph_q, flash_ph_d;
  logic [CNT_W-1:0] term;
  logic             done;
  logic             press;
  logic             clr;
  logic [4:0]       lamps;

  assign press = nb | sb;

  // GREEN is untimed; its term value is never consulted.
  always_comb begin
    term = CNT_W'(1);
    case (state_q)
      YELLOW:  term = CNT_W'(T_YEL);
      ALLRED:  term = CNT_W'(T_ALLRED);
      WALK:    term = CNT_W'(T_WALK);
      FLASH:   term = CNT_W'(T_FLASH);
      CLEAR:   term = CNT_W'(T_CLEAR);
      MINGRN:  term = CNT_W'(T_MIN_GREEN);
      default: term = CNT_W'(1);
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (tick_en),
    .term  (term),
    .done  (done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      GREEN:   if (press || req_pend_q) state_d = YELLOW;
      YELLOW:  if (done) state_d = ALLRED;
      ALLRED:  if (done) state_d = WALK;
      WALK:    if (done) state_d = FLASH;
      FLASH:   if (done) state_d = CLEAR;
      CLEAR:   if (done) state_d = MINGRN;
      MINGRN:  if (done) state_d = (req_pend_q || press) ? YELLOW : GREEN;
      default: state_d = GREEN;
    endcase
  end

  assign clr = (state_d != state_q);

  // Entering WALK serves the request, so the clear beats a same-edge press.
  always_comb begin
    req_pend_d = req_pend_q;
    if (state_d == WALK && state_q != WALK)
      req_pend_d = 1'b0;
    else if (state_q != WALK && state_q != FLASH && press)
      req_pend_d = 1'b1;
  end

  always_comb begin
    flash_ph_d = flash_ph_q;
    if (state_d == FLASH && state_q != FLASH) flash_ph_d = 1'b1;
    else if (state_q == FLASH && tick_en)     flash_ph_d = ~flash_ph_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= GREEN;
      req_pend_q <= 1'b0;
      flash_ph_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      req_pend_q <= req_pend_d;
      flash_ph_q <= flash_ph_d;
    end
  end

  always_comb begin
    lamps = LAMP_GREEN;
    case (state_q)
      GREEN:   lamps = LAMP_GREEN;
      YELLOW:  lamps = LAMP_YELLOW;
      ALLRED:  lamps = LAMP_ALLRED;
      WALK:    lamps = LAMP_WALK;
      FLASH:   lamps = {LAMP_FLASH, flash_ph_q};
      CLEAR:   lamps = LAMP_CLEAR;
      MINGRN:  lamps = LAMP_MINGRN;
      default: lamps = LAMP_GREEN;
    endcase
  end

  assign {tr, ty, tg, pr, pg} = lamps;
  assign wait_lamp            = req_pend_q;
  assign phase                = state_q;

endmodule
